wb_scoreboard: RTL and testbench

//  Writeback scheduler and hazard scoreboard for the 8x16 register bank (single write port, two async read ports).

---
 rtl/wb_scoreboard.sv | 120 ++++++++++++
 tb/tb_wb_scoreboard.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_scoreboard.sv
// Writeback scheduler and hazard scoreboard for the 8x16 register bank.
// Two writeback sources (ALU on port A, MEM on port B) share the bank's single
// write port under round-robin arbitration. A per-register busy bit tracks
// writes in flight, and issue is held off while a RAW or WAW hazard exists.
module wb_scoreboard #(
   parameter int DW = 16,
   parameter int AW = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                issue_valid,
   output logic                issue_ready,
   input  logic [AW-1:0]       issue_sr1,
   input  logic                issue_use1,
   input  logic [AW-1:0]       issue_sr2,
   input  logic                issue_use2,
   input  logic [AW-1:0]       issue_dr,
   input  logic                issue_wr,
   input  logic                a_valid,
   output logic                a_ready,
   input  logic [AW-1:0]       a_dr,
   input  logic [DW-1:0]       a_data,
   input  logic                b_valid,
   output logic                b_ready,
   input  logic [AW-1:0]       b_dr,
   input  logic [DW-1:0]       b_data,
   output logic                rf_write,
   output logic [AW-1:0]       rf_dr,
   output logic [DW-1:0]       rf_wrData,
   output logic [(2**AW)-1:0]  busy,
   output logic                wb_err,
   output logic [15:0]         stall_cnt
);

   localparam int NREG = 2**AW;

   // Round-robin memory: which requester received the most recent grant.
   localparam logic RR_A = 1'b0;
   localparam logic RR_B = 1'b1;

   logic            rr_last;
   logic            haz;
   logic            accept;
   logic            gnt;
   logic            gnt_live;
   logic [AW-1:0]   gnt_dr;
   logic [DW-1:0]   gnt_data;
   logic [NREG-1:0] busy_nxt;

   // Hazard check looks only at the registered busy bits; there is no bypass
   // from a write that commits in this same cycle.
   always_comb begin
      haz = (issue_use1 & busy[issue_sr1])
          | (issue_use2 & busy[issue_sr2])
          | (issue_wr   & busy[issue_dr]);
   end

   assign issue_ready = ~haz;
   assign accept      = issue_valid & ~haz;

   // One grant per cycle; on a tie the requester that did not win last time goes.
   always_comb begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      if (a_valid && (!b_valid || rr_last == RR_B)) begin
         a_ready = 1'b1;
      end else if (b_valid) begin
         b_ready = 1'b1;
      end
   end

   assign gnt      = a_ready | b_ready;
   assign gnt_dr   = a_ready ? a_dr : b_dr;
   assign gnt_data = a_ready ? a_data : b_data;
   assign gnt_live = gnt & (gnt_dr != '0);

   // Next busy vector: the committing write clears its bit, a new issue sets its
   // bit, and R0 is never tracked.
   always_comb begin
      busy_nxt = busy;
      if (rf_write) begin
         busy_nxt[rf_dr] = 1'b0;
      end
      if (accept && issue_wr && issue_dr != '0) begin
         busy_nxt[issue_dr] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   // Registered state: write pipeline stage, scoreboard, arbiter memory,
   // sticky error flag and the saturating stall counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_last   <= RR_B;
         rf_write  <= 1'b0;
         rf_dr     <= '0;
         rf_wrData <= '0;
         busy      <= '0;
         wb_err    <= 1'b0;
         stall_cnt <= '0;
      end else begin
         busy     <= busy_nxt;
         rf_write <= gnt_live;
         if (gnt) begin
            rr_last <= a_ready ? RR_A : RR_B;
         end
         if (gnt_live) begin
            rf_dr     <= gnt_dr;
            rf_wrData <= gnt_data;
            if (!busy[gnt_dr]) begin
               wb_err <= 1'b1;
            end
         end
         if (issue_valid && haz && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench for wb_scoreboard. A cycle-level reference model of the
// scoreboard (busy flags as an array, pending write, round-robin winner,
// sticky error, stall count) advances alongside the design at every edge.
module tb_wb_scoreboard;

   logic        clk;
   logic        reset;
   logic        issue_valid;
   logic        issue_ready;
   logic [2:0]  issue_sr1;
   logic        issue_use1;
   logic [2:0]  issue_sr2;
   logic        issue_use2;
   logic [2:0]  issue_dr;
   logic        issue_wr;
   logic        a_valid;
   logic        a_ready;
   logic [2:0]  a_dr;
   logic [15:0] a_data;
   logic        b_valid;
   logic        b_ready;
   logic [2:0]  b_dr;
   logic [15:0] b_data;
   logic        rf_write;
   logic [2:0]  rf_dr;
   logic [15:0] rf_wrData;
   logic [7:0]  busy;
   logic        wb_err;
   logic [15:0] stall_cnt;

   int compared;
   int mismatched;

   // Reference model state
   bit          m_busy[8];
   bit          m_last_a;
   bit          m_pv;
   int          m_pdr;
   logic [15:0] m_pdata;
   bit          m_err;
   int          m_stall;

   wb_scoreboard #(.DW(16), .AW(3)) dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_sr1(issue_sr1), .issue_use1(issue_use1),
      .issue_sr2(issue_sr2), .issue_use2(issue_use2),
      .issue_dr(issue_dr), .issue_wr(issue_wr),
      .a_valid(a_valid), .a_ready(a_ready), .a_dr(a_dr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_dr(b_dr), .b_data(b_data),
      .rf_write(rf_write), .rf_dr(rf_dr), .rf_wrData(rf_wrData),
      .busy(busy), .wb_err(wb_err), .stall_cnt(stall_cnt)
   );

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit m_haz();
      return (issue_use1 && m_busy[issue_sr1]) || (issue_use2 && m_busy[issue_sr2])
          || (issue_wr && m_busy[issue_dr]);
   endfunction

   function automatic bit m_ga();
      return a_valid && (!b_valid || !m_last_a);
   endfunction

   function automatic bit m_gb();
      return b_valid && !m_ga();
   endfunction

   function automatic logic [7:0] m_busy_vec();
      logic [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = m_busy[i];
      return v;
   endfunction

   // Advance one clock edge, updating the model from the inputs seen at the edge
   task automatic tick();
      bit ga, gb, acc, hz;
      bit old_busy[8];
      int gdr;
      logic [15:0] gd;
      ga  = m_ga();
      gb  = m_gb();
      hz  = m_haz();
      acc = issue_valid && !hz;
      gdr = ga ? int'(a_dr) : int'(b_dr);
      gd  = ga ? a_data : b_data;
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
         m_last_a = 1'b0;
         m_pv     = 1'b0;
         m_pdr    = 0;
         m_pdata  = '0;
         m_err    = 1'b0;
         m_stall  = 0;
      end else begin
         old_busy = m_busy;
         if (m_pv) m_busy[m_pdr] = 1'b0;
         if (acc && issue_wr && issue_dr != 0) m_busy[issue_dr] = 1'b1;
         if (issue_valid && hz && m_stall < 65535) m_stall++;
         if (ga || gb) begin
            if (gdr != 0 && !old_busy[gdr]) m_err = 1'b1;
            m_pv     = (gdr != 0);
            if (gdr != 0) begin
               m_pdr   = gdr;
               m_pdata = gd;
            end
            m_last_a = ga;
         end else begin
            m_pv = 1'b0;
         end
      end
      #1;
   endtask

   task automatic idle();
      issue_valid = 0; issue_sr1 = 0; issue_use1 = 0; issue_sr2 = 0; issue_use2 = 0;
      issue_dr = 0; issue_wr = 0;
      a_valid = 0; a_dr = 0; a_data = 0; b_valid = 0; b_dr = 0; b_data = 0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      tick();
      tick();
      reset = 0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      compared++; if (busy !== 8'h00) begin mismatched++;
         $display("[TB] FAIL reset_busy: got %h expected 00", busy); end
      compared++; if (rf_write !== 1'b0) begin mismatched++;
         $display("[TB] FAIL reset_rf_write: got %b expected 0", rf_write); end
      compared++; if (rf_dr !== 3'd0 || rf_wrData !== 16'h0) begin mismatched++;
         $display("[TB] FAIL reset_rf_bus: got dr=%0d data=%h expected 0/0000", rf_dr, rf_wrData); end
      compared++; if (wb_err !== 1'b0 || stall_cnt !== 16'h0) begin mismatched++;
         $display("[TB] FAIL reset_err_cnt: got err=%b cnt=%h expected 0/0000", wb_err, stall_cnt); end
      compared++; if (issue_ready !== 1'b1) begin mismatched++;
         $display("[TB] FAIL reset_ready: got %b expected 1", issue_ready); end
   endtask

   task automatic test_raw_stall();
      do_reset();
      issue_valid = 1; issue_wr = 1; issue_dr = 3;
      #1;
      compared++; if (issue_ready !== 1'b1) begin mismatched++;
         $display("[TB] FAIL raw_first_issue: got %b expected 1", issue_ready); end
      tick();
      issue_wr = 0; issue_dr = 0; issue_use1 = 1; issue_sr1 = 3;
      #1;
      compared++; if (issue_ready !== 1'b0 || busy !== 8'h08) begin mismatched++;
         $display("[TB] FAIL raw_stall: got ready=%b busy=%h expected 0/08", issue_ready, busy); end
      tick();
      a_valid = 1; a_dr = 3; a_data = 16'h00AA;
      #1;
      compared++; if (a_ready !== 1'b1) begin mismatched++;
         $display("[TB] FAIL raw_a_grant: got %b expected 1", a_ready); end
      tick();
      a_valid = 0;
      #1;
      compared++; if (rf_write !== 1'b1 || rf_dr !== 3'd3 || rf_wrData !== 16'h00AA) begin mismatched++;
         $display("[TB] FAIL raw_write: got w=%b dr=%0d d=%h expected 1/3/00aa", rf_write, rf_dr, rf_wrData); end
      compared++; if (issue_ready !== 1'b0 || busy !== 8'h08) begin mismatched++;
         $display("[TB] FAIL raw_pending_clear: got ready=%b busy=%h expected 0/08", issue_ready, busy); end
      tick();
      #1;
      compared++; if (busy !== 8'h00 || issue_ready !== 1'b1 || rf_write !== 1'b0) begin mismatched++;
         $display("[TB] FAIL raw_commit: got busy=%h ready=%b w=%b expected 00/1/0", busy, issue_ready, rf_write); end
      compared++; if (stall_cnt !== 16'd3) begin mismatched++;
         $display("[TB] FAIL raw_stall_cnt: got %0d expected 3", stall_cnt); end
      tick();
      idle();
      #1;
      compared++; if (stall_cnt !== 16'd3 || stall_cnt !== m_stall[15:0]) begin mismatched++;
         $display("[TB] FAIL raw_after_accept: got %0d expected 3", stall_cnt); end
   endtask

   task automatic test_round_robin();
      do_reset();
      issue_valid = 1; issue_wr = 1; issue_dr = 1;
      tick();
      issue_dr = 2;
      tick();
      idle();
      a_valid = 1; a_dr = 1; a_data = 16'h1111;
      b_valid = 1; b_dr = 2; b_data = 16'h2222;
      #1;
      compared++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin mismatched++;
         $display("[TB] FAIL rr_first_tie: got a=%b b=%b expected 1/0", a_ready, b_ready); end
      tick();
      a_valid = 0;
      #1;
      compared++; if (b_ready !== 1'b1 || rf_write !== 1'b1 || rf_dr !== 3'd1 || rf_wrData !== 16'h1111) begin mismatched++;
         $display("[TB] FAIL rr_second: got b=%b w=%b dr=%0d d=%h expected 1/1/1/1111", b_ready, rf_write, rf_dr, rf_wrData); end
      tick();
      b_valid = 0;
      #1;
      compared++; if (rf_write !== 1'b1 || rf_dr !== 3'd2 || rf_wrData !== 16'h2222 || wb_err !== 1'b0) begin mismatched++;
         $display("[TB] FAIL rr_b_write: got w=%b dr=%0d d=%h err=%b expected 1/2/2222/0", rf_write, rf_dr, rf_wrData, wb_err); end
      tick();
      #1;
      compared++; if (busy !== 8'h00 || rf_write !== 1'b0) begin mismatched++;
         $display("[TB] FAIL rr_drained: got busy=%h w=%b expected 00/0", busy, rf_write); end
      for (int k = 0; k < 6; k++) begin
         a_valid = 1; a_dr = 0; a_data = 16'($urandom);
         b_valid = 1; b_dr = 0; b_data = 16'($urandom);
         #1;
         compared++; if (a_ready !== ((k % 2) == 0) || b_ready !== ((k % 2) == 1)
                         || a_ready !== m_ga()) begin mismatched++;
            $display("[TB] FAIL rr_alternate_%0d: got a=%b b=%b expected a=%b", k, a_ready, b_ready, (k % 2) == 0); end
         tick();
      end
      idle();
   endtask

   task automatic test_dr0();
      do_reset();
      issue_valid = 1; issue_wr = 1; issue_dr = 0;
      #1;
      compared++; if (issue_ready !== 1'b1) begin mismatched++;
         $display("[TB] FAIL dr0_issue_ready: got %b expected 1", issue_ready); end
      tick();
      idle();
      #1;
      compared++; if (busy !== 8'h00) begin mismatched++;
         $display("[TB] FAIL dr0_busy: got %h expected 00", busy); end
      a_valid = 1; a_dr = 0; a_data = 16'hBEEF;
      #1;
      compared++; if (a_ready !== 1'b1) begin mismatched++;
         $display("[TB] FAIL dr0_grant: got %b expected 1", a_ready); end
      tick();
      a_valid = 0;
      #1;
      compared++; if (rf_write !== 1'b0 || wb_err !== 1'b0 || busy !== 8'h00) begin mismatched++;
         $display("[TB] FAIL dr0_no_write: got w=%b err=%b busy=%h expected 0/0/00", rf_write, wb_err, busy); end
   endtask

   task automatic test_random();
      bit ga, gb;
      int pick;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         if (!a_valid && $urandom_range(0, 2) == 0) begin
            pick = $urandom_range(0, 7);
            for (int r = 1; r < 8; r++) if (m_busy[r] && $urandom_range(0, 3) != 0) pick = r;
            a_valid = 1; a_dr = 3'(pick); a_data = 16'($urandom);
         end
         if (!b_valid && $urandom_range(0, 2) == 0) begin
            pick = $urandom_range(0, 7);
            for (int r = 7; r > 0; r--) if (m_busy[r] && $urandom_range(0, 3) != 0) pick = r;
            b_valid = 1; b_dr = 3'(pick); b_data = 16'($urandom);
         end
         issue_valid = 1'($urandom_range(0, 1));
         issue_sr1 = 3'($urandom); issue_use1 = 1'($urandom);
         issue_sr2 = 3'($urandom); issue_use2 = 1'($urandom);
         issue_dr  = 3'($urandom); issue_wr   = 1'($urandom);
         #1;
         compared++; if (issue_ready !== !m_haz() || a_ready !== m_ga() || b_ready !== m_gb()) begin mismatched++;
            $display("[TB] FAIL rand_comb_%0d: got r=%b a=%b b=%b expected %b/%b/%b",
                     c, issue_ready, a_ready, b_ready, !m_haz(), m_ga(), m_gb()); end
         compared++; if (rf_write !== m_pv || (m_pv && (rf_dr !== 3'(m_pdr) || rf_wrData !== m_pdata))) begin mismatched++;
            $display("[TB] FAIL rand_write_%0d: got w=%b dr=%0d d=%h expected %b/%0d/%h",
                     c, rf_write, rf_dr, rf_wrData, m_pv, m_pdr, m_pdata); end
         compared++; if (busy !== m_busy_vec() || wb_err !== m_err || stall_cnt !== m_stall[15:0]) begin mismatched++;
            $display("[TB] FAIL rand_state_%0d: got busy=%h err=%b cnt=%0d expected %h/%b/%0d",
                     c, busy, wb_err, stall_cnt, m_busy_vec(), m_err, m_stall); end
         ga = m_ga();
         gb = m_gb();
         tick();
         if (ga) a_valid = 0;
         if (gb) b_valid = 0;
      end
      idle();
   endtask

   task automatic test_reset_mid();
      do_reset();
      issue_valid = 1; issue_wr = 1; issue_dr = 4;
      tick();
      idle();
      a_valid = 1; a_dr = 4; a_data = 16'h4444;
      #1;
      compared++; if (a_ready !== 1'b1) begin mismatched++;
         $display("[TB] FAIL rmid_grant: got %b expected 1", a_ready); end
      tick();
      a_valid = 0;
      reset = 1;
      tick();
      reset = 0;
      #1;
      compared++; if (rf_write !== 1'b0 || busy !== 8'h00 || rf_wrData !== 16'h0 || rf_dr !== 3'd0) begin mismatched++;
         $display("[TB] FAIL rmid_dropped: got w=%b busy=%h dr=%0d d=%h expected 0/00/0/0000", rf_write, busy, rf_dr, rf_wrData); end
      tick();
      #1;
      compared++; if (rf_write !== 1'b0 || busy !== 8'h00) begin mismatched++;
         $display("[TB] FAIL rmid_after: got w=%b busy=%h expected 0/00", rf_write, busy); end
   endtask

   task automatic test_err_saturate();
      do_reset();
      b_valid = 1; b_dr = 5; b_data = 16'h5555;
      #1;
      compared++; if (b_ready !== 1'b1) begin mismatched++;
         $display("[TB] FAIL err_grant: got %b expected 1", b_ready); end
      tick();
      b_valid = 0;
      #1;
      compared++; if (wb_err !== 1'b1 || rf_write !== 1'b1 || rf_dr !== 3'd5 || rf_wrData !== 16'h5555) begin mismatched++;
         $display("[TB] FAIL err_set: got err=%b w=%b dr=%0d d=%h expected 1/1/5/5555", wb_err, rf_write, rf_dr, rf_wrData); end
      tick();
      #1;
      compared++; if (wb_err !== 1'b1 || busy !== 8'h00) begin mismatched++;
         $display("[TB] FAIL err_sticky: got err=%b busy=%h expected 1/00", wb_err, busy); end
      issue_valid = 1; issue_wr = 1; issue_dr = 6;
      tick();
      issue_wr = 0; issue_dr = 0; issue_use2 = 1; issue_sr2 = 6;
      repeat (65534) tick();
      #1;
      compared++; if (stall_cnt !== 16'hFFFE || stall_cnt !== m_stall[15:0]) begin mismatched++;
         $display("[TB] FAIL sat_before: got %h expected fffe", stall_cnt); end
      tick();
      #1;
      compared++; if (stall_cnt !== 16'hFFFF) begin mismatched++;
         $display("[TB] FAIL sat_reach: got %h expected ffff", stall_cnt); end
      repeat (5) tick();
      #1;
      compared++; if (stall_cnt !== 16'hFFFF || wb_err !== 1'b1) begin mismatched++;
         $display("[TB] FAIL sat_hold: got cnt=%h err=%b expected ffff/1", stall_cnt, wb_err); end
      idle();
   endtask

   // Test sequence
   initial begin
      compared   = 0;
      mismatched = 0;
      reset      = 1;
      idle();
      test_reset();
      test_raw_stall();
      test_round_robin();
      test_dr0();
      test_random();
      test_reset_mid();
      test_err_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
